// File: rtl/tl_cntr_nway.sv
// N-way round-robin traffic light controller with sensor-driven green, min/max green, yellow and all-red clearance.
// Optional emergency preemption inputs are compiled in with the TL_PREEMPT_EN macro.
module tl_cntr_nway #(
    parameter int N_WAY       = 4,
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 12,
    parameter int YELLOW_CYC  = 2,
    parameter int ALL_RED_CYC = 1,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_WAY-1:0]     T,
`ifdef TL_PREEMPT_EN
    input  logic                 preempt,
    input  logic [2:0]           preempt_dir,
`endif
    output logic [2*N_WAY-1:0]   L,
    output logic [2:0]           cur_dir,
    output logic [1:0]           phase,
    output logic                 switch_pls
);

    localparam int LW = 2 * N_WAY;

    localparam logic [1:0] PH_GREEN  = 2'b00;
    localparam logic [1:0] PH_YELLOW = 2'b01;
    localparam logic [1:0] PH_ALLRED = 2'b10;

    localparam logic [1:0] LAMP_G = 2'b00;
    localparam logic [1:0] LAMP_Y = 2'b01;
    localparam logic [1:0] LAMP_R = 2'b10;

    // Timer thresholds: the timer counts from 0, so a phase of length n ends at timer == n-1.
    localparam logic [CNT_W-1:0] MIN_LIM   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LIM   = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LIM   = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] AR_LIM    = CNT_W'((ALL_RED_CYC > 0) ? ALL_RED_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] TIMER_MAX = '1;

    logic [CNT_W-1:0] timer;
    logic [2:0]       next_dir;

    logic [1:0]       phase_nx;
    logic [2:0]       cur_nx;
    logic [2:0]       next_nx;
    logic             sw_nx;
    logic             enter;
    logic             cur_req;
    logic             other_req;
    logic             pre_valid;
    logic [2:0]       pre_dir;

    function automatic logic sensor(input logic [N_WAY-1:0] vec, input int idx);
        logic [N_WAY-1:0] s;
        s = vec >> idx;
        return s[0];
    endfunction

    // First requesting approach after cur, searching cur+1, cur+2, ... with wrap.
    function automatic logic [2:0] rr_pick(input logic [N_WAY-1:0] req, input logic [2:0] cur);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = cur;
        found = 1'b0;
        for (int k = 1; k < N_WAY; k++) begin
            idx = (int'(cur) + k) % N_WAY;
            if (!found && sensor(req, idx)) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [LW-1:0] lamp_word(input logic [1:0] ph, input logic [2:0] dir);
        logic [LW-1:0] w;
        logic [1:0]    code;
        w = '0;
        for (int i = 0; i < N_WAY; i++) begin
            code = LAMP_R;
            if (int'(dir) == i) begin
                case (ph)
                    PH_GREEN:  code = LAMP_G;
                    PH_YELLOW: code = LAMP_Y;
                    default:   code = LAMP_R;
                endcase
            end
            w = w | (LW'(code) << (2 * i));
        end
        return w;
    endfunction

`ifdef TL_PREEMPT_EN
    assign pre_valid = preempt && (int'(preempt_dir) < N_WAY);
    assign pre_dir   = preempt_dir;
`else
    assign pre_valid = 1'b0;
    assign pre_dir   = 3'd0;
`endif

    always_comb begin
        cur_req   = 1'b0;
        other_req = 1'b0;
        for (int j = 0; j < N_WAY; j++) begin
            if (j == int'(cur_dir))
                cur_req = sensor(T, j);
            else
                other_req = other_req | sensor(T, j);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        phase_nx = phase;
        cur_nx   = cur_dir;
        next_nx  = next_dir;
        sw_nx    = 1'b0;
        enter    = 1'b0;
        case (phase)
            PH_GREEN: begin
                if (pre_valid && (pre_dir != cur_dir)) begin
                    phase_nx = PH_YELLOW;
                    next_nx  = pre_dir;
                    enter    = 1'b1;
                end else if (!pre_valid && (timer >= MIN_LIM) && other_req &&
                             (!cur_req || (timer >= MAX_LIM))) begin
                    phase_nx = PH_YELLOW;
                    next_nx  = rr_pick(T, cur_dir);
                    enter    = 1'b1;
                end
            end
            PH_YELLOW: begin
                if (pre_valid)
                    next_nx = pre_dir;
                if (timer >= YEL_LIM) begin
                    enter = 1'b1;
                    if (ALL_RED_CYC == 0) begin
                        phase_nx = PH_GREEN;
                        cur_nx   = next_nx;
                        sw_nx    = 1'b1;
                    end else begin
                        phase_nx = PH_ALLRED;
                    end
                end
            end
            PH_ALLRED: begin
                if (pre_valid)
                    next_nx = pre_dir;
                if (timer >= AR_LIM) begin
                    enter    = 1'b1;
                    phase_nx = PH_GREEN;
                    cur_nx   = next_nx;
                    sw_nx    = 1'b1;
                end
            end
            default: begin
                // Unused encoding: recover to green on the current approach.
                phase_nx = PH_GREEN;
                enter    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= PH_GREEN;
            cur_dir    <= 3'd0;
            next_dir   <= 3'd0;
            timer      <= '0;
            switch_pls <= 1'b0;
            L          <= lamp_word(PH_GREEN, 3'd0);
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            phase      <= phase_nx;
            cur_dir    <= cur_nx;
            next_dir   <= next_nx;
            switch_pls <= sw_nx;
            L          <= lamp_word(phase_nx, cur_nx);
            if (enter)
                timer <= '0;
            else if (timer != TIMER_MAX)
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_tl_cntr_nway.sv
// Self-checking bench for tl_cntr_nway: directed scenarios plus randomized sensors against a cycle-count model.
module tb_tl_cntr_nway;

    localparam int N    = 4;
    localparam int MING = 4;
    localparam int MAXG = 12;
    localparam int YEL  = 2;
    localparam int AR   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] t_in = 4'b1111;
    logic [7:0] l_out;
    logic [2:0] cur_dir;
    logic [1:0] phase;
    logic       switch_pls;
`ifdef TL_PREEMPT_EN
    logic       preempt = 1'b0;
    logic [2:0] preempt_dir = 3'd0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase number, owning approach, pending approach, cycles already spent in phase.
    int m_ph, m_dir, m_next, m_age;
    bit m_sw;

    tl_cntr_nway #(
        .N_WAY(N), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
        .YELLOW_CYC(YEL), .ALL_RED_CYC(AR), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .T(t_in),
`ifdef TL_PREEMPT_EN
        .preempt(preempt),
        .preempt_dir(preempt_dir),
`endif
        .L(l_out),
        .cur_dir(cur_dir),
        .phase(phase),
        .switch_pls(switch_pls)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_lamps(input int ph, input int dir);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (i != dir)     w[2*i +: 2] = 2'b10;
            else if (ph == 0) w[2*i +: 2] = 2'b00;
            else if (ph == 1) w[2*i +: 2] = 2'b01;
            else              w[2*i +: 2] = 2'b10;
        end
        return w;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_dir = 0; m_next = 0; m_age = 0; m_sw = 0;
    endtask

    task automatic model_enter_green();
        m_ph = 0; m_dir = m_next; m_age = 0; m_sw = 1;
    endtask

    task automatic model_step(input logic [3:0] tv);
        bit others;
        m_sw = 0;
        if (m_ph == 0) begin
            others = 0;
            for (int j = 0; j < N; j++)
                if (j != m_dir && tv[j]) others = 1;
            if ((m_age + 1 >= MING) && others && (!tv[m_dir] || (m_age + 1 >= MAXG))) begin
                // Scan from farthest to nearest so the nearest requester wins.
                for (int k = N - 1; k >= 1; k--)
                    if (tv[(m_dir + k) % N]) m_next = (m_dir + k) % N;
                m_ph = 1; m_age = 0;
            end else begin
                m_age++;
            end
        end else if (m_ph == 1) begin
            if (m_age + 1 >= YEL) begin
                if (AR == 0) model_enter_green();
                else begin m_ph = 2; m_age = 0; end
            end else m_age++;
        end else begin
            if (m_age + 1 >= AR) model_enter_green();
            else m_age++;
        end
    endtask

    task automatic apply_reset(input logic [3:0] tv);
        reset = 1'b1;
        t_in  = tv;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        t_in  = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({l_out, phase, cur_dir, switch_pls} !== {8'b10101000, 2'b00, 3'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset k=%0d: got L=%b ph=%0d dir=%0d sw=%0d, want L=10101000 ph=0 dir=0 sw=0",
                         k, l_out, phase, cur_dir, switch_pls);
            end
        end
        #2;
        n_cmp++;
        if ({l_out, phase, cur_dir, switch_pls} !== {8'b10101000, 2'b00, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid: got L=%b ph=%0d dir=%0d sw=%0d", l_out, phase, cur_dir, switch_pls);
        end
    endtask

    task automatic test_no_other_req();
        apply_reset(4'b0001);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({l_out, phase, switch_pls} !== {8'hA8, 2'b00, 1'b0}) begin
                n_bad++;
                $display("FAIL hold k=%0d: got L=%h ph=%0d sw=%0d, want L=a8 ph=0 sw=0",
                         k, l_out, phase, switch_pls);
            end
        end
    endtask

    task automatic test_skip();
        logic [7:0] el; logic [1:0] ep; logic [2:0] ec; logic es;
        apply_reset(4'b0100);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            case (k)
                1, 2, 3: begin el = 8'hA8; ep = 2'd0; ec = 3'd0; es = 1'b0; end
                4, 5:    begin el = 8'hA9; ep = 2'd1; ec = 3'd0; es = 1'b0; end
                6:       begin el = 8'hAA; ep = 2'd2; ec = 3'd0; es = 1'b0; end
                7:       begin el = 8'h8A; ep = 2'd0; ec = 3'd2; es = 1'b1; end
                default: begin el = 8'h8A; ep = 2'd0; ec = 3'd2; es = 1'b0; end
            endcase
            n_cmp++;
            if ({l_out, phase, cur_dir, switch_pls} !== {el, ep, ec, es}) begin
                n_bad++;
                $display("FAIL skip k=%0d: got L=%h ph=%0d dir=%0d sw=%0d, want L=%h ph=%0d dir=%0d sw=%0d",
                         k, l_out, phase, cur_dir, switch_pls, el, ep, ec, es);
            end
        end
    endtask

    task automatic test_max_green();
        logic [7:0] el; logic [1:0] ep; logic [2:0] ec; logic es;
        apply_reset(4'b0011);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 11)      begin el = 8'hA8; ep = 2'd0; ec = 3'd0; es = 1'b0; end
            else if (k <= 13) begin el = 8'hA9; ep = 2'd1; ec = 3'd0; es = 1'b0; end
            else if (k == 14) begin el = 8'hAA; ep = 2'd2; ec = 3'd0; es = 1'b0; end
            else if (k == 15) begin el = 8'hA2; ep = 2'd0; ec = 3'd1; es = 1'b1; end
            else              begin el = 8'hA2; ep = 2'd0; ec = 3'd1; es = 1'b0; end
            n_cmp++;
            if ({l_out, phase, cur_dir, switch_pls} !== {el, ep, ec, es}) begin
                n_bad++;
                $display("FAIL max_green k=%0d: got L=%h ph=%0d dir=%0d sw=%0d, want L=%h ph=%0d dir=%0d sw=%0d",
                         k, l_out, phase, cur_dir, switch_pls, el, ep, ec, es);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 0;
        apply_reset(4'b0100);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (phase == 2'd1 && cur_dir == 3'd2) begin
                found = 1;
                break;
            end
            if (phase == 2'd0 && cur_dir == 3'd2) t_in = 4'b0001;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL async_reset_reach: yellow on approach 2 not seen within 40 cycles");
        end else begin
            #2 reset = 1'b1;
            #1;
            n_cmp++;
            if ({l_out, phase, cur_dir, switch_pls} !== {8'hA8, 2'b00, 3'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL async_reset: got L=%h ph=%0d dir=%0d sw=%0d, want L=a8 ph=0 dir=0 sw=0",
                         l_out, phase, cur_dir, switch_pls);
            end
            t_in = 4'b0000;
            @(negedge clk);
            reset = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                n_cmp++;
                if ({l_out, phase, cur_dir} !== {8'hA8, 2'b00, 3'd0}) begin
                    n_bad++;
                    $display("FAIL after_reset k=%0d: got L=%h ph=%0d dir=%0d, want L=a8 ph=0 dir=0",
                             k, l_out, phase, cur_dir);
                end
            end
        end
    endtask

`ifdef TL_PREEMPT_EN
    task automatic test_preempt();
        logic [7:0] el; logic [1:0] ep; logic [2:0] ec; logic es;
        preempt = 1'b0;
        apply_reset(4'b0000);
        @(negedge clk);
        preempt     = 1'b1;
        preempt_dir = 3'd3;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 2)      begin el = 8'hA9; ep = 2'd1; ec = 3'd0; es = 1'b0; end
            else if (k == 3) begin el = 8'hAA; ep = 2'd2; ec = 3'd0; es = 1'b0; end
            else             begin el = 8'h2A; ep = 2'd0; ec = 3'd3; es = 1'b1; end
            n_cmp++;
            if ({l_out, phase, cur_dir, switch_pls} !== {el, ep, ec, es}) begin
                n_bad++;
                $display("FAIL preempt k=%0d: got L=%h ph=%0d dir=%0d sw=%0d, want L=%h ph=%0d dir=%0d sw=%0d",
                         k, l_out, phase, cur_dir, switch_pls, el, ep, ec, es);
            end
        end
        t_in = 4'b0111;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({l_out, phase, cur_dir} !== {8'h2A, 2'b00, 3'd3}) begin
                n_bad++;
                $display("FAIL preempt_hold k=%0d: got L=%h ph=%0d dir=%0d, want L=2a ph=0 dir=3",
                         k, l_out, phase, cur_dir);
            end
        end
        preempt = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 2)      begin el = 8'h6A; ep = 2'd1; ec = 3'd3; es = 1'b0; end
            else if (k == 3) begin el = 8'hAA; ep = 2'd2; ec = 3'd3; es = 1'b0; end
            else             begin el = 8'hA8; ep = 2'd0; ec = 3'd0; es = 1'b1; end
            n_cmp++;
            if ({l_out, phase, cur_dir, switch_pls} !== {el, ep, ec, es}) begin
                n_bad++;
                $display("FAIL preempt_release k=%0d: got L=%h ph=%0d dir=%0d sw=%0d, want L=%h ph=%0d dir=%0d sw=%0d",
                         k, l_out, phase, cur_dir, switch_pls, el, ep, ec, es);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] tv;
        logic [7:0] el;
        int hold, nonred;
        model_reset();
        apply_reset(4'b0000);
        hold = 0;
        tv   = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       tv = 4'($urandom) & 4'($urandom);
                    1:       tv = 4'(1 << $urandom_range(0, 3));
                    2:       tv = 4'b0000;
                    default: tv = 4'($urandom);
                endcase
                hold = $urandom_range(1, 20);
            end
            hold--;
            t_in = tv;
            @(posedge clk);
            model_step(tv);
            @(negedge clk);
            el = exp_lamps(m_ph, m_dir);
            n_cmp++;
            if ({l_out, phase, cur_dir, switch_pls} !== {el, 2'(m_ph), 3'(m_dir), m_sw}) begin
                n_bad++;
                $display("FAIL random c=%0d T=%b: got L=%h ph=%0d dir=%0d sw=%0d, want L=%h ph=%0d dir=%0d sw=%0d",
                         c, tv, l_out, phase, cur_dir, switch_pls, el, m_ph, m_dir, m_sw);
            end
            nonred = 0;
            for (int i = 0; i < N; i++)
                if (l_out[2*i +: 2] != 2'b10) nonred++;
            n_cmp++;
            if (nonred > 1) begin
                n_bad++;
                $display("FAIL one_non_red c=%0d: got %0d non-red approaches (L=%h), want at most 1",
                         c, nonred, l_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_other_req();
        test_skip();
        test_max_green();
        test_async_reset();
`ifdef TL_PREEMPT_EN
        test_preempt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
